// File: rtl/fb_pixel_pkg.sv
// Shared types and helpers for the framebuffer pixel pipeline.
// Scale encoding, the debug grid colour and the effective scale shift.
package fb_pixel_pkg;

    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2
    } scale_t;

    localparam logic [2:0] GRID_COLOR = 3'b001;

    // Encoding 3 is not a distinct mode and behaves as 4x.
    function automatic logic [1:0] eff_shift(input logic [1:0] scale);
        if (scale == SCALE_1X)
            return 2'd0;
        else if (scale == SCALE_2X)
            return 2'd1;
        else
            return 2'd2;
    endfunction

endpackage

// File: rtl/fb_line_addr.sv
// Line base / row-repeat tracking and framebuffer read address generation.
// The address is combinational so the read is issued in the cycle the coordinate arrives.
module fb_line_addr
    import fb_pixel_pkg::*;
#(
    parameter int X_W    = 10,
    parameter int ADDR_W = 19
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_x_sync,
    input  logic              i_y_sync,
    input  logic              i_row_in_win,
    input  logic              i_in_win,
    input  logic [1:0]        i_shift,
    input  logic [X_W-1:0]    i_frame_width,
    input  logic [X_W-1:0]    i_col,
    output logic              o_fb_rd_en,
    output logic [ADDR_W-1:0] o_fb_addr
);

    logic [ADDR_W-1:0] r_lb;
    logic [ADDR_W-1:0] w_lb_next;
    logic [1:0]        r_rr;
    logic [1:0]        w_rr_next;
    logic [1:0]        w_rr_last;
    logic              r_row_seen;

    // A sync cycle already addresses with the updated base, so the first pixel of a line is right.
    always_comb begin
        w_lb_next = r_lb;
        w_rr_next = r_rr;
        w_rr_last = (i_shift == 2'd0) ? 2'd0 : (i_shift == 2'd1) ? 2'd1 : 2'd3;
        if (i_y_sync) begin
            w_lb_next = '0;
            w_rr_next = '0;
        end else if (i_x_sync && r_row_seen) begin
            if (r_rr >= w_rr_last) begin
                w_rr_next = '0;
                w_lb_next = r_lb + ADDR_W'(i_frame_width);
            end else begin
                w_rr_next = r_rr + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lb       <= '0;
            r_rr       <= '0;
            r_row_seen <= 1'b0;
        end else begin
            r_lb       <= w_lb_next;
            r_rr       <= w_rr_next;
            r_row_seen <= (i_x_sync || i_y_sync) ? i_row_in_win : (r_row_seen | i_row_in_win);
        end
    end

    assign o_fb_rd_en = i_in_win && !rst;
    assign o_fb_addr  = o_fb_rd_en ? (w_lb_next + ADDR_W'(i_col)) : '0;

endmodule

// File: rtl/fb_pixel_pipeline.sv
// Raster coordinate to coloured pixel: window compare, scaled addressing, palette and grid.
// Output lags the coordinate by FB_LATENCY+1 clocks in every mode.
module fb_pixel_pipeline
    import fb_pixel_pkg::*;
#(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int ADDR_W     = 19,
    parameter int BPP        = 1,
    parameter int PIX_W      = 3,
    parameter int FB_LATENCY = 1,
    parameter int GRID_SHIFT = 4
)
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [X_W-1:0]              i_x,
    input  logic [Y_W-1:0]              i_y,
    input  logic                        i_x_sync,
    input  logic                        i_y_sync,
    input  logic [X_W-1:0]              i_win_x,
    input  logic [Y_W-1:0]              i_win_y,
    input  logic [X_W-1:0]              i_frame_width,
    input  logic [Y_W-1:0]              i_frame_height,
    input  logic [1:0]                  i_scale,
    input  logic                        i_grid_en,
    input  logic [PIX_W-1:0]            i_border_color,
    input  logic [(2**BPP)*PIX_W-1:0]   i_palette,
    output logic                        o_fb_rd_en,
    output logic [ADDR_W-1:0]           o_fb_addr,
    input  logic [BPP-1:0]              i_fb_data,
    output logic [PIX_W-1:0]            o_pixel_data,
    output logic                        o_pixel_valid
);

    localparam logic [PIX_W-1:0] GRID_PIX = PIX_W'(GRID_COLOR);

    logic [1:0]     w_shift;
    logic [X_W+2:0] w_sw;
    logic [X_W+2:0] w_x_end;
    logic [Y_W+2:0] w_sh;
    logic [Y_W+2:0] w_y_end;
    logic           w_col_in;
    logic           w_row_in;
    logic           w_in_win;
    logic           w_grid;
    logic [X_W-1:0] w_col;
    logic [PIX_W-1:0] w_pix;

    logic [FB_LATENCY-1:0] r_win_d;
    logic [FB_LATENCY-1:0] r_grid_d;
    logic [FB_LATENCY-1:0] r_valid_d;
    logic [PIX_W-1:0]      r_pixel_data;
    logic                  r_pixel_valid;

    // Extents are widened so a window running past the raster edge clips instead of wrapping.
    assign w_shift  = eff_shift(i_scale);
    assign w_sw     = {3'b000, i_frame_width} << w_shift;
    assign w_sh     = {3'b000, i_frame_height} << w_shift;
    assign w_x_end  = {3'b000, i_win_x} + w_sw;
    assign w_y_end  = {3'b000, i_win_y} + w_sh;
    assign w_col_in = (i_x >= i_win_x) && ({3'b000, i_x} < w_x_end);
    assign w_row_in = (i_y >= i_win_y) && ({3'b000, i_y} < w_y_end);
    assign w_in_win = w_col_in && w_row_in;
    assign w_col    = (i_x - i_win_x) >> w_shift;
    assign w_grid   = i_grid_en && ((i_x[GRID_SHIFT-1:0] == '0) || (i_y[GRID_SHIFT-1:0] == '0));

    fb_line_addr #(
        .X_W    (X_W),
        .ADDR_W (ADDR_W)
    ) u_line_addr (
        .clk           (clk),
        .rst           (rst),
        .i_x_sync      (i_x_sync),
        .i_y_sync      (i_y_sync),
        .i_row_in_win  (w_row_in),
        .i_in_win      (w_in_win),
        .i_shift       (w_shift),
        .i_frame_width (i_frame_width),
        .i_col         (w_col),
        .o_fb_rd_en    (o_fb_rd_en),
        .o_fb_addr     (o_fb_addr)
    );

    always_comb begin
        w_pix = i_border_color;
        if (r_grid_d[FB_LATENCY-1])
            w_pix = GRID_PIX;
        else if (r_win_d[FB_LATENCY-1])
            w_pix = i_palette[int'(i_fb_data)*PIX_W +: PIX_W];
    end

    // Delay line keeps the per-coordinate flags level with the returning framebuffer data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_d       <= '0;
            r_grid_d      <= '0;
            r_valid_d     <= '0;
            r_pixel_data  <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            r_win_d[0]   <= w_in_win;
            r_grid_d[0]  <= w_grid;
            r_valid_d[0] <= 1'b1;
            for (int i = 1; i < FB_LATENCY; i++) begin
                r_win_d[i]   <= r_win_d[i-1];
                r_grid_d[i]  <= r_grid_d[i-1];
                r_valid_d[i] <= r_valid_d[i-1];
            end
            r_pixel_data  <= w_pix;
            r_pixel_valid <= r_valid_d[FB_LATENCY-1];
        end
    end

    assign o_pixel_data  = r_pixel_data;
    assign o_pixel_valid = r_pixel_valid;

endmodule
